// File: rtl/ibus_sram_responder.sv
// Instruction-bus slave model: preloadable SRAM behind an in-order
// outstanding queue with fixed response latency.
package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_sram_responder
  import ibus_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  ibus_req_t                    ireq,
  output ibus_resp_t                   iresp,
  input  logic                         init_en,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [31:0]                  init_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]         mem_q [MEM_WORDS];

  logic [AW-1:0]       idx_q [QUEUE_DEPTH];
  logic [AW-1:0]       idx_d [QUEUE_DEPTH];
  logic [3:0]          cnt_q [QUEUE_DEPTH];
  logic [3:0]          cnt_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic                retire;
  logic                addr_ok;
  logic                accept;
  logic                unused_ok;

  assign unused_ok = ^{ireq.addr[31:AW+2], ireq.addr[1:0], ireq.size};

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign retire  = (count_q != '0) && (cnt_q[head_q] == '0);
  assign addr_ok = (count_q < CW'(QUEUE_DEPTH)) || retire;
  assign accept  = ireq.valid && addr_ok;

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (vld_q[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
    if (retire) begin
      vld_d[head_q] = 1'b0;
      head_d        = wrap_inc(head_q);
    end
    // Accept after retire: when full, tail == head and the slot is reused.
    if (accept) begin
      vld_d[tail_q] = 1'b1;
      idx_d[tail_q] = ireq.addr[AW+1:2];
      cnt_d[tail_q] = 4'(LATENCY - 1);
      tail_d        = wrap_inc(tail_q);
    end
    unique case ({accept, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        idx_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init_en) begin
      mem_q[init_addr] <= init_data;
    end
  end

  always_comb begin
    iresp         = '0;
    iresp.addr_ok = addr_ok;
    iresp.data_ok = retire;
    iresp.data    = retire ? mem_q[idx_q[head_q]] : '0;
  end

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench for ibus_sram_responder: two configurations,
// cycle-stamped scoreboard of expected responses.
module tb_ibus_sram_responder;
  import ibus_pkg::*;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  ibus_req_t  ireq_a, ireq_b;
  ibus_resp_t iresp_a, iresp_b;
  logic       init_en;
  logic [9:0] init_addr;
  logic [31:0] init_data;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ibus_sram_responder #(
    .MEM_WORDS(1024), .LATENCY(2), .QUEUE_DEPTH(2)
  ) u_a (
    .clk(clk), .resetn(resetn),
    .ireq(ireq_a), .iresp(iresp_a),
    .init_en(init_en), .init_addr(init_addr),
    .init_data(init_data)
  );

  ibus_sram_responder #(
    .MEM_WORDS(1024), .LATENCY(3), .QUEUE_DEPTH(1)
  ) u_b (
    .clk(clk), .resetn(resetn),
    .ireq(ireq_b), .iresp(iresp_b),
    .init_en(init_en), .init_addr(init_addr),
    .init_data(init_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic ea, eb;
    while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
    while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
    ea = (qa.size() > 0) && (qa[0].due == cyc);
    eb = (qb.size() > 0) && (qb[0].due == cyc);
    chk("a_data_ok", 32'(iresp_a.data_ok), 32'(ea));
    if (ea) begin
      chk("a_data", iresp_a.data, qa[0].data);
      void'(qa.pop_front());
    end else begin
      chk("a_data_idle", iresp_a.data, 32'h0);
    end
    chk("b_data_ok", 32'(iresp_b.data_ok), 32'(eb));
    if (eb) begin
      chk("b_data", iresp_b.data, qb[0].data);
      void'(qb.pop_front());
    end else begin
      chk("b_data_idle", iresp_b.data, 32'h0);
    end
  endtask

  task automatic tick(input logic ie = 1'b0,
                      input logic [9:0] ia = '0,
                      input logic [31:0] idat = '0);
    @(posedge clk);
    cyc++;
    #1;
    init_en   = ie;
    init_addr = ia;
    init_data = idat;
    @(negedge clk);
    mon();
  endtask

  task automatic step_a(input logic v, input logic [31:0] a,
                        input logic aok, input logic [31:0] ed,
                        input logic ie = 1'b0,
                        input logic [9:0] ia = '0,
                        input logic [31:0] idat = '0);
    ireq_a = '{valid: v, addr: a, size: 2'b10};
    #1;
    chk("a_addr_ok", 32'(iresp_a.addr_ok), 32'(aok));
    if (v && aok) qa.push_back('{cyc + 2, ed});
    tick(ie, ia, idat);
  endtask

  task automatic step_b(input logic v, input logic [31:0] a,
                        input logic aok, input logic [31:0] ed);
    ireq_b = '{valid: v, addr: a, size: 2'b10};
    #1;
    chk("b_addr_ok", 32'(iresp_b.addr_ok), 32'(aok));
    if (v && aok) qb.push_back('{cyc + 3, ed});
    tick();
  endtask

  initial begin
    logic [31:0] wd [4];
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    resetn    = 1'b0;
    ireq_a    = '0;
    ireq_b    = '0;
    init_en   = 1'b0;
    init_addr = '0;
    init_data = '0;
    #2;
    chk("rst_addr_ok", 32'(iresp_a.addr_ok), 32'h1);
    chk("rst_data_ok", 32'(iresp_a.data_ok), 32'h0);
    chk("rst_data", iresp_a.data, 32'h0);
    @(negedge clk);

    tick(1'b1, 10'h10, 32'h2402_0005);
    for (int i = 0; i < 4; i++) tick(1'b1, 10'(i), wd[i]);
    tick(1'b1, 10'h5, 32'hAAAA_AAAA);
    resetn = 1'b1;
    tick();

    // single fetch, word 0x10
    step_a(1'b1, 32'h40, 1'b1, 32'h2402_0005);
    repeat (3) step_a(1'b0, 32'h0, 1'b1, 32'h0);

    // back-to-back
    step_a(1'b1, 32'h0, 1'b1, 32'h11);
    step_a(1'b1, 32'h4, 1'b1, 32'h22);
    step_a(1'b1, 32'h8, 1'b1, 32'h33);
    repeat (3) step_a(1'b0, 32'h0, 1'b1, 32'h0);

    // wrap and misalignment
    step_a(1'b1, 32'h0000_1003, 1'b1, 32'h11);
    repeat (3) step_a(1'b0, 32'h0, 1'b1, 32'h0);

    // preload in the retire cycle of word 5
    step_a(1'b1, 32'h14, 1'b1, 32'hAAAA_AAAA);
    step_a(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 10'h5, 32'h5555_5555);
    step_a(1'b0, 32'h0, 1'b1, 32'h0);
    step_a(1'b1, 32'h14, 1'b1, 32'h5555_5555);
    repeat (3) step_a(1'b0, 32'h0, 1'b1, 32'h0);

    // reset with two outstanding
    step_a(1'b1, 32'h0, 1'b1, 32'h11);
    ireq_a = '{valid: 1'b1, addr: 32'h4, size: 2'b10};
    #1;
    chk("a_addr_ok", 32'(iresp_a.addr_ok), 32'h1);
    @(posedge clk);
    cyc++;
    #1;
    resetn = 1'b0;
    ireq_a = '0;
    qa.delete();
    @(negedge clk);
    mon();
    chk("in_rst_addr_ok", 32'(iresp_a.addr_ok), 32'h1);
    @(posedge clk);
    cyc++;
    #1;
    resetn = 1'b1;
    @(negedge clk);
    mon();
    chk("post_rst_addr_ok", 32'(iresp_a.addr_ok), 32'h1);
    repeat (2) step_a(1'b0, 32'h0, 1'b1, 32'h0);
    step_a(1'b1, 32'h8, 1'b1, 32'h33);
    repeat (3) step_a(1'b0, 32'h0, 1'b1, 32'h0);

    // depth 1, latency 3, valid held
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step_b(1'b1, 32'(4 * i), 1'b0, 32'h0);
        step_b(1'b1, 32'(4 * i), 1'b0, 32'h0);
      end
      step_b(1'b1, 32'(4 * i), 1'b1, wd[i]);
    end
    step_b(1'b0, 32'h0, 1'b0, 32'h0);
    step_b(1'b0, 32'h0, 1'b0, 32'h0);
    step_b(1'b0, 32'h0, 1'b1, 32'h0);
    step_b(1'b0, 32'h0, 1'b1, 32'h0);

    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibus_sram_responder.md
# ibus_sram_responder

Slave-side model of the instruction bus. It accepts `ibus_req_t` fetch requests through the `addr_ok` handshake, holds them in an in-order outstanding queue, and returns `ibus_resp_t` data with a one-cycle `data_ok` pulse after a fixed latency. It sits opposite the fetch stage (`S_FETCH` / `S_FETCH_ADDR_SENT`) in refcpu simulation tops and unit benches. It replaces ad-hoc bus stubs with a deterministic, preloadable instruction memory.

## Interface
- `MEM_WORDS`, 1024: backing store depth in 32-bit words; power of two.
- `LATENCY`, 2: cycles from acceptance to `data_ok`; legal range 1..15.
- `QUEUE_DEPTH`, 2: maximum number of outstanding accepted requests; legal range 1..8.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireq`  in  `ibus_req_t`  fetch request from the CPU (`valid`, `addr`, `size`).
- `iresp`  out  `ibus_resp_t`  response to the CPU (`addr_ok`, `data_ok`, `data`).
- `init_en`  in  1  preload write strobe.
- `init_addr`  in  $clog2(MEM_WORDS)  preload word index.
- `init_data`  in  32  preload word.

## Operation
- Word index of a request is `addr[$clog2(MEM_WORDS)+1:2]`. `addr[1:0]` and upper bits are ignored, so the address wraps modulo the memory size. `size` is ignored and a full word is always returned.
- Queue: circular buffer of `QUEUE_DEPTH` entries. Each entry holds a word index and a down-counter. `count` is 0..QUEUE_DEPTH.
- `retire` = queue non-empty and the head counter equals 0.
- `addr_ok` = (`count` < `QUEUE_DEPTH`) OR `retire`. It depends only on registered state and never on `ireq`, so there is no combinational loop.
- Accept = `ireq.valid` AND `addr_ok`. On accept, the tail entry is written with counter = `LATENCY`-1 and the tail pointer advances with wrap.
- Every cycle, each occupied entry with counter > 0 decrements by 1.
- Retire: `data_ok`=1 and `data` = mem[head index], read combinationally from the array. The head pointer advances with wrap.
- `data` = 0 whenever `data_ok`=0.
- Simultaneous accept and retire: `count` is unchanged. This is legal when full.
- A request that is not accepted (`valid`=1, `addr_ok`=0) leaves no state change. The CPU holds `valid`.
- Responses return strictly in acceptance order, at most one `data_ok` per cycle.
- Preload: when `init_en`=1, mem[`init_addr`] <= `init_data` at the clock edge. A retire in the same cycle to the same word returns the old word (read-before-write).
- `init_en` has no effect on the handshake.

## Timing
- Reset (`resetn`=0, asynchronous) clears pointers, `count` and counters. During reset: `addr_ok`=1, `data_ok`=0, `data`=0.
- Memory contents are not cleared by reset.
- Reset mid-operation drops all outstanding requests. No `data_ok` is produced for any request accepted before reset.
- A request accepted in cycle T (rising edge ending T) produces `data_ok` in cycle T+`LATENCY`.
- `LATENCY`=1: `data_ok` appears in the cycle immediately after acceptance.
- Sustained throughput is 1 request/cycle when `QUEUE_DEPTH` >= `LATENCY`. Otherwise `addr_ok` drops when `count`=`QUEUE_DEPTH` with no retire pending.
- `data_ok` is a single-cycle pulse per request, with no ready/back-pressure from the CPU.

## Test plan
- Preload mem[0x10]=0x2402_0005. Reset, then a single request with addr 0x40, `LATENCY`=2. Required: `addr_ok`=1 at the accepting edge; `data_ok`=1 with `data`=0x2402_0005 exactly 2 cycles later; `data_ok`=0 and `data`=0 on all other cycles.
- Back-to-back requests 0x0, 0x4, 0x8 (words preloaded 0x11, 0x22, 0x33) with `LATENCY`=2, `QUEUE_DEPTH`=2. Required: all three accepted on consecutive cycles, and `data_ok` on three consecutive cycles returning 0x11, 0x22, 0x33 in order.
- `QUEUE_DEPTH`=1, `LATENCY`=3, `valid` held on four addresses. Required: `addr_ok` low for 2 cycles after each accept, rising in the retire cycle; one response every 3 cycles, in order.
- Address wrap and alignment with `MEM_WORDS`=1024: addr 0x0000_1003. Required: returns mem[0] content.
- Same-cycle preload and retire on word 5 (old 0xAAAA_AAAA, new 0x5555_5555). Required: `data`=0xAAAA_AAAA; a later fetch of word 5 returns 0x5555_5555.
- Assert `resetn`=0 for one cycle while 2 requests are outstanding. Required: no `data_ok` for either request; `addr_ok`=1 immediately after reset; the next request completes after `LATENCY` cycles with correct data.
